// File: rtl/uart_frame_tx_pkg.sv
// Shared types and constants for the UART response-frame sequencer.
package uart_frame_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DELAY,
        LOAD,
        WAIT,
        GAP
    } frame_state_e;

    localparam logic [7:0] CRC8_POLY      = 8'h07;
    localparam logic [7:0] CRC8_INIT      = 8'h00;
    localparam logic [7:0] HEADER_DEFAULT = 8'h80;
    localparam logic [7:0] TAIL_DEFAULT   = 8'h55;

endpackage

// File: rtl/uart_frame_crc8.sv
// One byte step of CRC-8 (MSB-first, no reflection); the register lives in the parent.
module uart_frame_crc8
    import uart_frame_tx_pkg::*;
(
    input  logic [7:0] crc_i,
    input  logic [7:0] data_i,
    output logic [7:0] crc_o
);

    logic [7:0] acc;

    always_comb begin
        acc = crc_i ^ data_i;
        for (int b = 0; b < 8; b++) begin
            acc = acc[7] ? ((acc << 1) ^ CRC8_POLY) : (acc << 1);
        end
        crc_o = acc;
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Sequences HEADER, payload, optional CRC-8 and TAIL into an external UART byte transmitter.
module uart_frame_tx
    import uart_frame_tx_pkg::*;
#(
    parameter int unsigned N_PAYLOAD   = 3,
    parameter logic [7:0]  HEADER      = HEADER_DEFAULT,
    parameter logic [7:0]  TAIL        = TAIL_DEFAULT,
    parameter int unsigned CRC_EN      = 1,
    parameter int unsigned START_DELAY = 16,
    parameter int unsigned GAP_CYCLES  = 15,
    parameter int unsigned TX_TIMEOUT  = 8192
) (
    input  logic                     clk_50M,
    input  logic                     rst,
    input  logic                     send_req,
    input  logic [8*N_PAYLOAD-1:0]   payload,
    output logic                     tx_en,
    output logic [7:0]               tx_data,
    input  logic                     tx_busy,
    input  logic                     tx_done,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     req_dropped,
    output logic                     tx_timeout
);

    localparam int unsigned FRAME_LEN  = N_PAYLOAD + 2 + CRC_EN;
    localparam int unsigned IDX_W      = $clog2(FRAME_LEN + 1);
    localparam int unsigned CNT_MAX    = (START_DELAY > GAP_CYCLES) ? START_DELAY : GAP_CYCLES;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);
    localparam int unsigned TMR_W      = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;
    localparam int unsigned DELAY_LAST = START_DELAY - 1;
    localparam int unsigned GAP_LAST   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int unsigned TMR_LAST   = (TX_TIMEOUT > 0) ? TX_TIMEOUT - 1 : 0;

    frame_state_e           state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [7:0]             crc_q, crc_d;
    logic [8*N_PAYLOAD-1:0] snap_q, snap_d;
    logic                   pending_q, pending_d;
    logic                   tx_en_q, tx_en_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   busy_q;
    logic                   frame_done_q, frame_done_d;
    logic                   req_dropped_q, req_dropped_d;
    logic                   tx_timeout_q, tx_timeout_d;

    logic [7:0]             cur_byte;
    logic [7:0]             crc_step;
    logic                   is_payload;

    uart_frame_crc8 u_crc8 (
        .crc_i  (crc_q),
        .data_i (tx_data_q),
        .crc_o  (crc_step)
    );

    // Byte at the current frame index
    always_comb begin
        cur_byte = TAIL;
        if (idx_q == '0) begin
            cur_byte = HEADER;
        end
        for (int k = 0; k < N_PAYLOAD; k++) begin
            if (idx_q == IDX_W'(k + 1)) begin
                cur_byte = snap_q[8*k +: 8];
            end
        end
        if (CRC_EN != 0 && idx_q == IDX_W'(N_PAYLOAD + 1)) begin
            cur_byte = crc_q;
        end
    end

    assign is_payload = (idx_q != '0) && (idx_q <= IDX_W'(N_PAYLOAD));

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        tmr_d         = tmr_q;
        crc_d         = crc_q;
        snap_d        = snap_q;
        pending_d     = pending_q;
        tx_en_d       = 1'b0;
        tx_data_d     = tx_data_q;
        frame_done_d  = 1'b0;
        req_dropped_d = 1'b0;
        tx_timeout_d  = 1'b0;

        // One-deep queue; the first queued request wins
        if (state_q != IDLE && send_req) begin
            if (pending_q) begin
                req_dropped_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (send_req) begin
                    snap_d  = payload;
                    crc_d   = CRC8_INIT;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = DELAY;
                end
            end
            DELAY: begin
                if (cnt_q == CNT_W'(DELAY_LAST)) begin
                    cnt_d   = '0;
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD: begin
                if (!tx_busy) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = cur_byte;
                    tmr_d     = '0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (tx_done) begin
                    if (is_payload) begin
                        crc_d = crc_step;
                    end
                    cnt_d   = '0;
                    state_d = GAP;
                end else if (TX_TIMEOUT != 0) begin
                    if (tmr_q == TMR_W'(TMR_LAST)) begin
                        tx_timeout_d = 1'b1;
                        pending_d    = 1'b0;
                        state_d      = IDLE;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(GAP_LAST)) begin
                    cnt_d = '0;
                    if (idx_q != IDX_W'(FRAME_LEN - 1)) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = LOAD;
                    end else begin
                        frame_done_d = 1'b1;
                        if (pending_q || send_req) begin
                            // Back-to-back frame: snapshot now, a same-cycle request re-arms the queue
                            snap_d        = payload;
                            crc_d         = CRC8_INIT;
                            idx_d         = '0;
                            pending_d     = pending_q && send_req;
                            req_dropped_d = 1'b0;
                            state_d       = DELAY;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            tmr_q         <= '0;
            crc_q         <= CRC8_INIT;
            snap_q        <= '0;
            pending_q     <= 1'b0;
            tx_en_q       <= 1'b0;
            tx_data_q     <= 8'h00;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            req_dropped_q <= 1'b0;
            tx_timeout_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            tmr_q         <= tmr_d;
            crc_q         <= crc_d;
            snap_q        <= snap_d;
            pending_q     <= pending_d;
            tx_en_q       <= tx_en_d;
            tx_data_q     <= tx_data_d;
            busy_q        <= (state_d != IDLE);
            frame_done_q  <= frame_done_d;
            req_dropped_q <= req_dropped_d;
            tx_timeout_q  <= tx_timeout_d;
        end
    end

    assign tx_en       = tx_en_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign req_dropped = req_dropped_q;
    assign tx_timeout  = tx_timeout_q;

endmodule
